// File: rtl/bench_pkg.sv
// Shared types and constants for the SHA-256 benchmark controller.
// Holds the FSM encoding, block/digest geometry and the nonce insertion helper.
package bench_pkg;

  localparam int DIGEST_W            = 256;
  localparam int BLOCK_BYTES         = 64;
  localparam int NONCE_OFFSET        = 60;
  localparam int DEFAULT_CLK_FREQ_HZ = 12_000_000;
  localparam int MAX_BENCH_SECONDS   = 600;
  localparam int SECONDS_W           = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

  // Overwrite the last four bytes with the nonce, most significant byte first.
  function automatic block_t insert_nonce(input block_t tmpl, input logic [31:0] nonce);
    block_t blk;
    blk = tmpl;
    for (int i = 0; i < 4; i++) begin
      blk[NONCE_OFFSET+i] = nonce[31-8*i -: 8];
    end
    return blk;
  endfunction

endpackage

// File: rtl/bench_timer.sv
// Benchmark window timer: a clk-cycle prescaler feeding a seconds counter.
// Counting freezes once the window has expired so the seconds value never wraps.
module bench_timer
  import bench_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = DEFAULT_CLK_FREQ_HZ,
  parameter int BENCHMARKSECONDS = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic expired
);

  localparam int                   PRE_W    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);
  localparam logic [SECONDS_W-1:0] LIMIT    = SECONDS_W'(BENCHMARKSECONDS);

  logic [PRE_W-1:0]     prescaler;
  logic [SECONDS_W-1:0] seconds;

  assign expired = (seconds >= LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      prescaler <= '0;
      seconds   <= '0;
    end else if (!expired) begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        seconds   <= seconds + SECONDS_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/bench_ctrl.sv
// Benchmark controller: repeatedly launches hashes of a nonce-stamped block
// for a fixed time window and counts how many digests complete.
module bench_ctrl
  import bench_pkg::*;
#(
  parameter int BENCHMARKSECONDS = 10,
  parameter int CLK_FREQ_HZ      = DEFAULT_CLK_FREQ_HZ,
  parameter int COUNT_W          = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [BLOCK_BYTES-1:0][7:0] input_buffer,
  input  logic                        sha_ready,
  input  logic                        sha_done,
  input  logic [DIGEST_W-1:0]         sha_digest,
  output logic                        sha_start,
  output logic [BLOCK_BYTES-1:0][7:0] sha_block,
  output logic                        busy,
  output logic                        done,
  output logic [COUNT_W-1:0]          hash_count,
  output logic [DIGEST_W-1:0]         last_digest
);

  if (BENCHMARKSECONDS < 0 || BENCHMARKSECONDS > MAX_BENCH_SECONDS) begin : g_bad_seconds
    $fatal(1, "bench_ctrl: BENCHMARKSECONDS must be within 0..600");
  end
  if (CLK_FREQ_HZ < 1) begin : g_bad_freq
    $fatal(1, "bench_ctrl: CLK_FREQ_HZ must be at least 1");
  end
  if (COUNT_W < 1) begin : g_bad_width
    $fatal(1, "bench_ctrl: COUNT_W must be at least 1");
  end

  state_t             state, state_nx;
  logic [COUNT_W-1:0] nonce;
  logic [31:0]        nonce_lo;
  logic               expired;
  logic               accept;
  logic               take_done;

  bench_timer #(
    .CLK_FREQ_HZ      (CLK_FREQ_HZ),
    .BENCHMARKSECONDS (BENCHMARKSECONDS)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept),
    .expired (expired)
  );

  if (COUNT_W >= 32) begin : g_nonce_wide
    assign nonce_lo = nonce[31:0];
  end else begin : g_nonce_narrow
    assign nonce_lo = {{(32-COUNT_W){1'b0}}, nonce};
  end

  assign sha_block = insert_nonce(input_buffer, nonce_lo);
  assign accept    = (state == ST_IDLE) && start;
  // Digests are only meaningful while a hash is actually in flight.
  assign take_done = sha_done && ((state == ST_WAIT) || (state == ST_DRAIN));
  assign busy      = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_DRAIN);

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    sha_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (expired) begin
          state_nx = ST_FINISH;
        end else if (sha_ready) begin
          sha_start = 1'b1;
          state_nx  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sha_done)     state_nx = expired ? ST_FINISH : ST_ISSUE;
        else if (expired) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (sha_done) state_nx = ST_FINISH;
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // NOTE: last_digest is a plain datapath register, but it is cleared on reset
  // because software reads it and must never see a stale value from before reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      hash_count  <= '0;
      nonce       <= '0;
      last_digest <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        done       <= 1'b0;
        hash_count <= '0;
        nonce      <= '0;
      end else begin
        if (take_done) begin
          if (hash_count != '1) hash_count <= hash_count + COUNT_W'(1);
          nonce       <= nonce + COUNT_W'(1);
          last_digest <= sha_digest;
        end
        if (state_nx == ST_FINISH) done <= 1'b1;
      end
    end
  end

endmodule
